// File: rtl/tthbif_rf.sv
// UART-command register file for TT-HBIF lanes: per-lane tap selects, lane mode
// (loopback / PRBS7 / const0 / const1) and a self-synchronising PRBS7 checker.
module tthbif_rf #(
    parameter int NUM_LANES = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   en_i,
    input  logic                   rx_valid_i,
    input  logic [7:0]             rx_data_i,
    input  logic                   tx_ready_i,
    output logic                   tx_valid_o,
    output logic [7:0]             tx_data_o,
    output logic [2*NUM_LANES-1:0] comb_tap_sel_o,
    output logic [2*NUM_LANES-1:0] flop_tap_sel_o,
    input  logic [NUM_LANES-1:0]   lane_rx_i,
    output logic [NUM_LANES-1:0]   lane_tx_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    localparam logic [1:0] MODE_LOOP   = 2'd0;
    localparam logic [1:0] MODE_PRBS   = 2'd1;
    localparam logic [1:0] MODE_ZERO   = 2'd2;
    localparam logic [6:0] LFSR_SEED   = 7'h7F;
    localparam logic [6:0] ADDR_NLANES = 7'h7F;
    localparam logic [7:0] NUM_LANES_B = 8'(NUM_LANES);

    // x^7+x^6+1: shift left, feed back bit6^bit5.
    function automatic logic [6:0] prbs7_next(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[5]};
    endfunction

    // With hist[0] the newest bit, b[n] = b[n-6] ^ b[n-7].
    function automatic logic prbs7_predict(input logic [6:0] h);
        return h[6] ^ h[5];
    endfunction

    state_e                 state_q, state_d;
    logic [6:0]             wr_addr_q, wr_addr_d;
    logic                   tx_valid_q, tx_valid_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   wr_fire_s;
    logic [6:0]             rd_addr_s;
    logic [7:0]             rd_data_s;
    logic [8*NUM_LANES-1:0] lane_rd_s;

    assign rd_addr_s  = rx_data_i[6:0];
    assign tx_valid_o = tx_valid_q;
    assign tx_data_o  = tx_data_q;

    // Read-data mux for the address carried by the current command byte.
    always_comb begin
        rd_data_s = 8'h00;
        if (rd_addr_s == ADDR_NLANES) begin
            rd_data_s = NUM_LANES_B;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                rd_data_s = rd_data_s |
                    ((rd_addr_s[6:2] == 5'(i)) ? lane_rd_s[8*i +: 8] : 8'h00);
            end
        end
    end

    // Command FSM next-state and response capture.
    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        wr_fire_s  = 1'b0;
        if (!en_i) begin
            state_d    = ST_IDLE;
            tx_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_valid_i) begin
                        if (rx_data_i[7]) begin
                            wr_addr_d = rx_data_i[6:0];
                            state_d   = ST_WDATA;
                        end else begin
                            tx_data_d  = rd_data_s;
                            tx_valid_d = 1'b1;
                            state_d    = ST_RESP;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WDATA: begin
                    if (rx_valid_i) begin
                        wr_fire_s = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_WDATA;
                    end
                end
                ST_RESP: begin
                    // Bytes arriving here are intentionally dropped.
                    if (tx_valid_q && tx_ready_i) begin
                        tx_valid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    tx_valid_d = 1'b0;
                end
            endcase
        end
    end

    // Command FSM state and response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            wr_addr_q  <= 7'h00;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        logic [5:0] ctrl_q, ctrl_d;
        logic [6:0] lfsr_q, lfsr_d;
        logic [6:0] hist_q, hist_d;
        logic [2:0] fill_q, fill_d;
        logic [3:0] good_q, good_d;
        logic       lock_q, lock_d;
        logic [7:0] err_q, err_d;
        logic       hit_s, ctrl_we_s, clr_we_s, mode_chg_s, eval_s, bit_err_s;
        logic       tx_bit_s;
        logic [7:0] rd_s;

        assign hit_s      = wr_fire_s && (wr_addr_q[6:2] == 5'(gi));
        assign ctrl_we_s  = hit_s && (wr_addr_q[1:0] == 2'd0);
        assign clr_we_s   = hit_s && (wr_addr_q[1:0] == 2'd1);
        assign mode_chg_s = ctrl_we_s && (rx_data_i[5:4] != ctrl_q[5:4]);
        // A mode change restarts the history fill, so that edge is not evaluated.
        assign eval_s     = (fill_q == 3'd7) && !mode_chg_s;
        assign bit_err_s  = eval_s && (prbs7_predict(hist_q) != lane_rx_i[gi]);

        // Lane control, generator, checker and error-counter next state.
        always_comb begin
            ctrl_d = ctrl_q;
            lfsr_d = lfsr_q;
            hist_d = {hist_q[5:0], lane_rx_i[gi]};
            fill_d = fill_q;
            good_d = good_q;
            lock_d = lock_q;
            err_d  = err_q;
            if (ctrl_we_s) begin
                ctrl_d = rx_data_i[5:0];
            end else begin
                ctrl_d = ctrl_q;
            end
            if (mode_chg_s) begin
                lfsr_d = LFSR_SEED;
                fill_d = 3'd0;
                good_d = 4'd0;
                lock_d = 1'b0;
            end else begin
                if (ctrl_q[5:4] == MODE_PRBS) begin
                    lfsr_d = prbs7_next(lfsr_q);
                end else begin
                    lfsr_d = lfsr_q;
                end
                if (fill_q != 3'd7) begin
                    fill_d = fill_q + 3'd1;
                end else begin
                    fill_d = fill_q;
                end
                // good_q saturates at 15; the 16th clean bit sets lock.
                if (bit_err_s) begin
                    good_d = 4'd0;
                    lock_d = 1'b0;
                end else if (eval_s) begin
                    if (good_q == 4'd15) begin
                        lock_d = 1'b1;
                    end else begin
                        good_d = good_q + 4'd1;
                    end
                end else begin
                    good_d = good_q;
                    lock_d = lock_q;
                end
            end
            if (clr_we_s) begin
                err_d = 8'h00;
            end else if (bit_err_s && (ctrl_q[5:4] == MODE_PRBS) && (err_q != 8'hFF)) begin
                err_d = err_q + 8'h01;
            end else begin
                err_d = err_q;
            end
        end

        // Lane state registers.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                ctrl_q <= 6'h0F;
                lfsr_q <= LFSR_SEED;
                hist_q <= 7'h00;
                fill_q <= 3'd0;
                good_q <= 4'd0;
                lock_q <= 1'b0;
                err_q  <= 8'h00;
            end else begin
                ctrl_q <= ctrl_d;
                lfsr_q <= lfsr_d;
                hist_q <= hist_d;
                fill_q <= fill_d;
                good_q <= good_d;
                lock_q <= lock_d;
                err_q  <= err_d;
            end
        end

        // Lane output select; loopback is a deliberate combinational bypass.
        always_comb begin
            case (ctrl_q[5:4])
                MODE_LOOP: tx_bit_s = lane_rx_i[gi];
                MODE_PRBS: tx_bit_s = lfsr_q[6];
                MODE_ZERO: tx_bit_s = 1'b0;
                default:   tx_bit_s = 1'b1;
            endcase
        end

        // Per-lane register read view.
        always_comb begin
            case (rd_addr_s[1:0])
                2'd0:    rd_s = {2'b00, ctrl_q};
                2'd1:    rd_s = err_q;
                2'd2:    rd_s = {7'h00, lock_q};
                default: rd_s = 8'h00;
            endcase
        end

        assign lane_tx_o[gi]             = tx_bit_s;
        assign comb_tap_sel_o[2*gi +: 2] = ctrl_q[1:0];
        assign flop_tap_sel_o[2*gi +: 2] = ctrl_q[3:2];
        assign lane_rd_s[8*gi +: 8]      = rd_s;
    end

endmodule

// File: tb/tb_tthbif_rf.sv
// Directed bench for tthbif_rf with four lanes; lane 0 can be looped back
// through a half-cycle sampled path so the PRBS checker sees its own generator.
module tb_tthbif_rf;

    logic       clk = 1'b0;
    logic       rst_ni, en_i, rx_valid_i, tx_ready_i;
    logic [7:0] rx_data_i;
    logic       tx_valid_o;
    logic [7:0] tx_data_o;
    logic [7:0] comb_tap_sel_o, flop_tap_sel_o;
    logic [3:0] lane_rx_i, lane_tx_o;
    logic [3:0] rx_stim;
    logic       loop_en, loop_bit, flip;
    logic [7:0] rd_val;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         unstable;

    always #5 clk = ~clk;

    // Lane 0 loopback sample: copies the transmitted bit away from the clock edge.
    always @(negedge clk) loop_bit = lane_tx_o[0];

    assign lane_rx_i = loop_en ? {rx_stim[3:1], loop_bit ^ flip} : rx_stim;

    tthbif_rf #(.NUM_LANES(4)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .en_i           (en_i),
        .rx_valid_i     (rx_valid_i),
        .rx_data_i      (rx_data_i),
        .tx_ready_i     (tx_ready_i),
        .tx_valid_o     (tx_valid_o),
        .tx_data_o      (tx_data_o),
        .comb_tap_sel_o (comb_tap_sel_o),
        .flop_tap_sel_o (flop_tap_sel_o),
        .lane_rx_i      (lane_rx_i),
        .lane_tx_o      (lane_tx_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All tasks are entered just after a negedge and return just after one.
    task automatic send_byte(input logic [7:0] b);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        @(negedge clk);
        rx_valid_i = 1'b0;
    endtask

    task automatic write_reg(input logic [6:0] a, input logic [7:0] d);
        send_byte({1'b1, a});
        send_byte(d);
    endtask

    task automatic read_reg(input logic [6:0] a, output logic [7:0] d);
        send_byte({1'b0, a});
        check_eq("rd_valid", 32'(tx_valid_o), 32'd1);
        d          = tx_data_o;
        tx_ready_i = 1'b1;
        @(negedge clk);
        tx_ready_i = 1'b0;
        check_eq("rd_done", 32'(tx_valid_o), 32'd0);
    endtask

    initial begin
        rst_ni     = 1'b0;
        en_i       = 1'b1;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        tx_ready_i = 1'b0;
        rx_stim    = 4'b1010;
        loop_en    = 1'b0;
        flip       = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_txv",  32'(tx_valid_o), 32'd0);
        check_eq("rst_txd",  32'(tx_data_o), 32'h00);
        check_eq("rst_comb", 32'(comb_tap_sel_o), 32'hFF);
        check_eq("rst_flop", 32'(flop_tap_sel_o), 32'hFF);
        check_eq("rst_loop", 32'(lane_tx_o), 32'hA);
        rst_ni = 1'b1;
        @(negedge clk);
        read_reg(7'h00, rd_val); check_eq("ctrl0_rst", 32'(rd_val), 32'h0F);
        read_reg(7'h7F, rd_val); check_eq("nlanes", 32'(rd_val), 32'd4);
        read_reg(7'h01, rd_val); check_eq("err0_rst", 32'(rd_val), 32'h00);

        // CTRL write / read-back
        write_reg(7'h00, 8'h16);
        check_eq("wr_comb", 32'(comb_tap_sel_o), 32'hFE);
        check_eq("wr_flop", 32'(flop_tap_sel_o), 32'hFD);
        read_reg(7'h00, rd_val); check_eq("ctrl0_16", 32'(rd_val), 32'h16);
        write_reg(7'h00, 8'hFF);
        read_reg(7'h00, rd_val); check_eq("ctrl0_ff", 32'(rd_val), 32'h3F);
        check_eq("mode3_tx", 32'(lane_tx_o[0]), 32'd1);

        // PRBS loopback: 7 fill bits + 16 clean bits after the mode-change edge
        write_reg(7'h00, 8'h10);
        loop_en = 1'b1;
        check_eq("prbs_seed_bit", 32'(lane_tx_o[0]), 32'd1);
        repeat (23) @(negedge clk);
        read_reg(7'h02, rd_val); check_eq("lock_23", 32'(rd_val), 32'h01);
        repeat (1000) @(negedge clk);
        read_reg(7'h01, rd_val); check_eq("err_clean", 32'(rd_val), 32'h00);
        read_reg(7'h02, rd_val); check_eq("lock_hold", 32'(rd_val), 32'h01);

        // One flipped bit is seen three times: as received, then at the two
        // later predictions that use it (taps n-6 and n-7).
        flip = 1'b1;
        @(negedge clk);
        flip = 1'b0;
        repeat (8) @(negedge clk);
        read_reg(7'h02, rd_val); check_eq("lock_drop", 32'(rd_val), 32'h00);
        repeat (20) @(negedge clk);
        read_reg(7'h02, rd_val); check_eq("lock_back", 32'(rd_val), 32'h01);
        read_reg(7'h01, rd_val); check_eq("err_flip", 32'(rd_val), 32'h03);

        // Inverted stream: every evaluated bit is an error
        flip = 1'b1;
        repeat (300) @(negedge clk);
        read_reg(7'h01, rd_val); check_eq("err_sat", 32'(rd_val), 32'hFF);
        repeat (20) @(negedge clk);
        read_reg(7'h01, rd_val); check_eq("err_sat_hold", 32'(rd_val), 32'hFF);
        flip = 1'b0;
        repeat (10) @(negedge clk);
        write_reg(7'h01, 8'h5A);
        read_reg(7'h01, rd_val); check_eq("err_clear", 32'(rd_val), 32'h00);
        read_reg(7'h00, rd_val); check_eq("ctrl_after_clr", 32'(rd_val), 32'h10);

        // Flow control: response held, a write command sent during RESP is dropped
        send_byte(8'h00);
        unstable = 0;
        for (int k = 0; k < 50; k++) begin
            if (k == 20) begin
                rx_valid_i = 1'b1;
                rx_data_i  = 8'h80;
            end else begin
                rx_valid_i = 1'b0;
            end
            @(negedge clk);
            if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h10) unstable++;
        end
        rx_valid_i = 1'b0;
        check_eq("resp_stable", 32'(unstable), 32'd0);
        tx_ready_i = 1'b1;
        @(negedge clk);
        tx_ready_i = 1'b0;
        check_eq("resp_done", 32'(tx_valid_o), 32'd0);
        read_reg(7'h00, rd_val); check_eq("drop_cmd", 32'(rd_val), 32'h10);

        // en_i low aborts a pending response
        send_byte(8'h7F);
        check_eq("en_pre", 32'(tx_valid_o), 32'd1);
        en_i = 1'b0;
        @(negedge clk);
        check_eq("en_drop", 32'(tx_valid_o), 32'd0);
        en_i = 1'b1;
        @(negedge clk);
        check_eq("en_idle", 32'(tx_valid_o), 32'd0);
        read_reg(7'h7F, rd_val); check_eq("en_read", 32'(rd_val), 32'd4);

        // Lane modes on other lanes and the combinational bypass
        write_reg(7'h04, 8'h20);
        check_eq("l1_comb", 32'(comb_tap_sel_o), 32'hF0);
        check_eq("l1_const0", 32'(lane_tx_o[3:1]), 32'b100);
        rx_stim = 4'b0100;
        #1;
        check_eq("bypass", 32'(lane_tx_o[3:1]), 32'b010);
        @(negedge clk);

        // Unmapped addresses
        read_reg(7'h10, rd_val); check_eq("rd_lane4", 32'(rd_val), 32'h00);
        read_reg(7'h03, rd_val); check_eq("rd_rsvd", 32'(rd_val), 32'h00);
        read_reg(7'h7E, rd_val); check_eq("rd_7e", 32'(rd_val), 32'h00);
        write_reg(7'h10, 8'h00);
        check_eq("wr4_comb", 32'(comb_tap_sel_o), 32'hF0);
        check_eq("wr4_flop", 32'(flop_tap_sel_o), 32'hF0);

        // Async reset while waiting for write data
        loop_en = 1'b0;
        send_byte(8'h80);
        rx_valid_i = 1'b1;
        rx_data_i  = 8'h00;
        rst_ni     = 1'b0;
        #1;
        check_eq("arst_comb", 32'(comb_tap_sel_o), 32'hFF);
        check_eq("arst_flop", 32'(flop_tap_sel_o), 32'hFF);
        @(negedge clk);
        rx_valid_i = 1'b0;
        rst_ni     = 1'b1;
        @(negedge clk);
        read_reg(7'h00, rd_val); check_eq("arst_ctrl0", 32'(rd_val), 32'h0F);
        read_reg(7'h04, rd_val); check_eq("arst_ctrl1", 32'(rd_val), 32'h0F);
        check_eq("arst_loop", 32'(lane_tx_o), 32'(rx_stim));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
